// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
package piso_pkg;

  localparam int unsigned PISO_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_e;

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding buffer: captures a word while the shifter is busy.
module piso_hold_buf
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  // load and pop are mutually exclusive by construction (load needs empty, pop needs full)
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      dout <= '0;
      full <= 1'b0;
    end else if (load) begin
      dout <= din;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer for gapless frames.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  piso_state_e      state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt, out_valid_nxt, frame_start_nxt;

  logic             hold_full, hold_load, hold_pop;
  logic [WIDTH-1:0] hold_data;
  logic             accept, last_data, frame_end, load_word;
  logic [WIDTH-1:0] next_word;

`ifdef PISO_SERIALIZER_PARITY_EN
  logic par, par_nxt;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .clear (clear),
    .load  (hold_load),
    .pop   (hold_pop),
    .din   (din),
    .dout  (hold_data),
    .full  (hold_full)
  );

  // Handshake and frame-boundary decode
  assign din_ready = ~hold_full;
  assign busy      = (state != IDLE);
  assign accept    = din_valid & din_ready;
  assign last_data = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
`ifdef PISO_SERIALIZER_PARITY_EN
  assign frame_end = (state == PARITY);
`else
  assign frame_end = last_data;
`endif
  // The buffer is always empty in IDLE, so din is the only source there
  assign load_word = ((state == IDLE) && accept) || (frame_end && (hold_full || accept));
  assign next_word = hold_full ? hold_data : din;
  assign hold_load = accept && (state != IDLE) && !frame_end;
  assign hold_pop  = frame_end && hold_full;

  // State register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_word) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_data) begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = load_word ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        state_nxt = load_word ? SHIFT : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; the counter idles at zero and restarts on every load
  always_comb begin
    sreg_nxt        = sreg;
    cnt_nxt         = '0;
    out_nxt         = 1'b0;
    out_valid_nxt   = 1'b0;
    frame_start_nxt = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_nxt         = par;
`endif
    if (load_word) begin
      sreg_nxt        = advance(next_word);
      out_nxt         = first_bit(next_word);
      out_valid_nxt   = 1'b1;
      frame_start_nxt = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_nxt         = ^next_word;
`endif
    end else if ((state == SHIFT) && !last_data) begin
      sreg_nxt      = advance(sreg);
      cnt_nxt       = cnt + CNT_W'(1);
      out_nxt       = first_bit(sreg);
      out_valid_nxt = 1'b1;
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    else if (last_data) begin
      cnt_nxt       = cnt + CNT_W'(1);
      out_nxt       = par;
      out_valid_nxt = 1'b1;
    end
`endif
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sreg        <= '0;
      cnt         <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      sreg        <= sreg_nxt;
      cnt         <= cnt_nxt;
      out         <= out_nxt;
      out_valid   <= out_valid_nxt;
      frame_start <= frame_start_nxt;
`ifdef PISO_SERIALIZER_PARITY_EN
      par         <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus.
// Honors PISO_SERIALIZER_PARITY_EN by expecting an extra even-parity bit per frame.
module tb_piso_serializer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         clear;
  logic [W-1:0] din;
  logic         din_valid;
  logic         rdy_m, out_m, ov_m, fs_m, busy_m;
  logic         rdy_l, out_l, ov_l, fs_l, busy_l;

  int total = 0;
  int bad   = 0;
  int waited;

  // entries are {expected bit, expected frame_start}
  logic [1:0] qm[$];
  logic [1:0] ql[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clear(clear), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .out(out_m), .out_valid(ov_m), .frame_start(fs_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clear(clear), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .out(out_l), .out_valid(ov_l), .frame_start(fs_l), .busy(busy_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected serial image of one word for both bit orders
  task automatic push(input logic [W-1:0] w);
    for (int i = 0; i < int'(W); i++) begin
      qm.push_back({w[W-1-i], (i == 0)});
      ql.push_back({w[i], (i == 0)});
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    qm.push_back({^w, 1'b0});
    ql.push_back({^w, 1'b0});
`endif
  endtask

  // Present a word, wait (bounded) for din_ready, then let it be taken on the next edge
  task automatic send(input logic [W-1:0] w, output int wcnt);
    din       = w;
    din_valid = 1'b1;
    wcnt      = 0;
    while (!rdy_m && wcnt < 50) begin
      @(posedge clk); #1;
      wcnt++;
    end
    if (!rdy_m) begin
      total++;
      bad++;
      $display("FAIL send_timeout: word %0h never accepted, din_ready=%0b want 1", w, rdy_m);
    end else begin
      @(posedge clk); #1;
      push(w);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy_m"}, 32'(busy_m), 0);
    check({name, "_busy_l"}, 32'(busy_l), 0);
    check({name, "_out_m"}, 32'({out_m, ov_m}), 0);
    check({name, "_drain_m"}, 32'(qm.size()), 0);
    check({name, "_drain_l"}, 32'(ql.size()), 0);
  endtask

  // Monitor: pop and compare whenever an instance presents a bit
  always @(negedge clk) begin
    logic [1:0] e;
    if (ov_m) begin
      if (qm.size() == 0) begin
        total++; bad++;
        $display("FAIL msb_extra: got bit %0b with nothing expected", out_m);
      end else begin
        e = qm.pop_front();
        check("msb_bit_fs", 32'({out_m, fs_m}), 32'(e));
      end
    end else begin
      check("msb_quiet", 32'({out_m, fs_m}), 0);
    end
    if (ov_l) begin
      if (ql.size() == 0) begin
        total++; bad++;
        $display("FAIL lsb_extra: got bit %0b with nothing expected", out_l);
      end else begin
        e = ql.pop_front();
        check("lsb_bit_fs", 32'({out_l, fs_l}), 32'(e));
      end
    end else begin
      check("lsb_quiet", 32'({out_l, fs_l}), 0);
    end
  end

  initial begin
    clear     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    #21;
    check("rst_out", 32'({out_m, ov_m, fs_m}), 0);
    check("rst_busy", 32'({busy_m, busy_l}), 0);
    check("rst_ready", 32'({rdy_m, rdy_l}), 32'b11);
    clear = 1'b0;

    // Single frame straight after clear
    send(4'b1010, waited);
    din_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_idle("single");

    // Back-to-back frames with a third word stalled on a full buffer
    send(4'b1010, waited);
    send(4'b0110, waited);
    check("held_ready_m", 32'(rdy_m), 0);
    check("held_ready_l", 32'(rdy_l), 0);
    send(4'b1111, waited);
    check("third_stalled", 32'(waited >= 2), 1);
    din_valid = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    check_idle("b2b");

    // Clear in the middle of a frame
    send(4'b1100, waited);
    din_valid = 1'b0;
    @(negedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    clear = 1'b1;
    qm.delete();
    ql.delete();
    #1;
    check("clr_out", 32'({out_m, ov_m, fs_m, out_l, ov_l}), 0);
    check("clr_busy", 32'({busy_m, busy_l}), 0);
    check("clr_ready", 32'(rdy_m), 1);
    @(posedge clk); #1;
    clear = 1'b0;
    send(4'b0011, waited);
    check("post_clr_wait", 32'(waited), 0);
    din_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_idle("post_clr");

    // Parity vectors (plain data frames when parity is disabled)
    send(4'b1011, waited);
    send(4'b1001, waited);
    din_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check_idle("parity");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=100000", $time);
    $fatal(1);
  end

endmodule
